// File: rtl/crop_window_ctrl.sv
// Top-edge crop sequencer: searches one frame for the start row, then forwards a
// CROP_W x CROP_H window of the following frame beginning at that row.
module crop_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CROP_X0  = 160,
  parameter int CROP_W   = 320,
  parameter int CROP_H   = 240
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [9:0]  iDATA,
  input  logic [15:0] iYSTART,
  input  logic        iSTART,
  input  logic        iABORT,
  output logic [9:0]  oDATA,
  output logic        oDVAL,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [15:0] oYSEL
);

  localparam logic [15:0] LP_X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] LP_Y_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] LP_Y_MAX  = 16'(V_ACTIVE - CROP_H);
  localparam logic [16:0] LP_X_LO   = 17'(CROP_X0);
  localparam logic [16:0] LP_X_HI   = 17'(CROP_X0 + CROP_W);
  localparam logic [16:0] LP_H17    = 17'(CROP_H);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_SEARCH   = 3'd2,
    S_CHECK    = 3'd3,
    S_WAIT_CAP = 3'd4,
    S_CAPTURE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_ysel;
  logic [15:0] w_ysel_next;
  logic [9:0]  r_data;
  logic        r_dval;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        w_sof;
  logic        w_eof;
  logic        w_in_win;
  logic        w_out_vld;
  logic        w_err_now;
  logic        w_done_now;

  assign w_sof = iDVAL && (r_x == 16'd0) && (r_y == 16'd0);
  assign w_eof = iDVAL && (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);

  // 17-bit sums keep ysel+CROP_H from wrapping near the top of the 16-bit range
  assign w_in_win = ({1'b0, r_x} >= LP_X_LO) && ({1'b0, r_x} < LP_X_HI) &&
                    ({1'b0, r_y} >= {1'b0, r_ysel}) &&
                    ({1'b0, r_y} < ({1'b0, r_ysel} + LP_H17));

  assign w_out_vld = (r_state == S_CAPTURE) && iDVAL && !iABORT && w_in_win;

  // raster position counters, free-running on valid pixels in every state
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x <= 16'd0;
      r_y <= 16'd0;
    end else if (iDVAL) begin
      if (r_x == LP_X_LAST) begin
        r_x <= 16'd0;
        r_y <= (r_y == LP_Y_LAST) ? 16'd0 : r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  // state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state, start-row selection and status pulse decode; abort wins over all
  always_comb begin
    w_next      = r_state;
    w_ysel_next = r_ysel;
    w_err_now   = 1'b0;
    w_done_now  = 1'b0;
    if (iABORT && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iSTART) w_next = S_WAIT_SOF;
          else        w_next = S_IDLE;
        end
        S_WAIT_SOF: begin
          if (w_sof) w_next = S_SEARCH;
          else       w_next = S_WAIT_SOF;
        end
        S_SEARCH: begin
          if (w_eof) begin
            w_ysel_next = iYSTART;
            w_next      = S_CHECK;
          end else begin
            w_next = S_SEARCH;
          end
        end
        S_CHECK: begin
          if (r_ysel == 16'd0) begin
            w_err_now = 1'b1;
            w_next    = S_IDLE;
          end else begin
            if (r_ysel > LP_Y_MAX) w_ysel_next = LP_Y_MAX;
            else                   w_ysel_next = r_ysel;
            w_next = S_WAIT_CAP;
          end
        end
        S_WAIT_CAP: begin
          if (w_sof) w_next = S_CAPTURE;
          else       w_next = S_WAIT_CAP;
        end
        S_CAPTURE: begin
          if (w_eof) w_next = S_DONE;
          else       w_next = S_CAPTURE;
        end
        S_DONE: begin
          w_done_now = 1'b1;
          w_next     = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // registered datapath and status; busy/done/err line up so busy drops with the pulse
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_data <= 10'd0;
      r_dval <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ysel <= 16'd0;
    end else begin
      r_dval <= w_out_vld;
      if (w_out_vld) r_data <= iDATA;
      r_busy <= (w_next != S_IDLE);
      r_done <= w_done_now;
      r_err  <= w_err_now;
      r_ysel <= w_ysel_next;
    end
  end

  assign oDATA = r_data;
  assign oDVAL = r_dval;
  assign oBUSY = r_busy;
  assign oDONE = r_done;
  assign oERR  = r_err;
  assign oYSEL = r_ysel;

endmodule

// File: doc/crop_window_ctrl.md
Name: crop_window_ctrl

Overview:
Sequencer for the top-edge crop path in the capture pipeline. On a capture request it spends one full frame letting the upstream Y-start detector search, then latches the detected start row. It then gates the following frame so that only a CROP_W x CROP_H window beginning at that row is forwarded downstream. It reports busy, done and error status to the capture control logic.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
CROP_X0, 160, first column of crop window
CROP_W, 320, crop window width in pixels
CROP_H, 240, crop window height in lines

Ports:
iCLK  input  1  pixel clock
iRST  input  1  asynchronous active-low reset
iDVAL  input  1  input pixel valid
iDATA  input  10  input pixel data
iYSTART  input  16  start row reported by the Y-start detector; stable at end of frame
iSTART  input  1  capture request; single-cycle pulse
iABORT  input  1  abandon the current capture
oDATA  output  10  cropped pixel data
oDVAL  output  1  cropped pixel valid
oBUSY  output  1  high in any state other than IDLE
oDONE  output  1  one-cycle pulse when a capture completes
oERR  output  1  one-cycle pulse when no edge was found
oYSEL  output  16  start row in use for the current or last capture

Behaviour:
- Reset (iRST low, asynchronous) sets state to IDLE and clears the X and Y counters.
- Reset also clears oDATA, oDVAL, oBUSY, oDONE, oERR and oYSEL to 0.
- Reset mid-capture abandons the capture with no oDONE and no oERR.
- Position counters:
  - 16-bit X and Y counters advance only on iDVAL.
  - X wraps at H_ACTIVE-1 and then increments Y.
  - Y wraps at V_ACTIVE-1.
  - The counters run in every state.
  - SOF = iDVAL with X==0 and Y==0. EOF = iDVAL with X==H_ACTIVE-1 and Y==V_ACTIVE-1.
- States:
  - IDLE: iSTART moves to WAIT_SOF. iSTART in any other state is ignored.
  - WAIT_SOF: SOF moves to SEARCH. The SOF pixel belongs to the SEARCH frame.
  - SEARCH: at EOF, latch iYSTART into ysel and move to CHECK.
  - CHECK: one cycle.
    - If ysel==0, pulse oERR and go to IDLE.
    - If ysel > V_ACTIVE-CROP_H, clamp ysel to V_ACTIVE-CROP_H.
    - Otherwise go to WAIT_CAP.
  - WAIT_CAP: next SOF moves to CAPTURE. The SOF pixel belongs to the CAPTURE frame.
  - CAPTURE: at EOF move to DONE.
  - DONE: one cycle, oDONE=1, then IDLE.
- iABORT: in any non-IDLE state, go to IDLE on the next clock with no pulse. iABORT takes priority over every other transition in the same cycle.
- Datapath:
  - oDATA and oDVAL are registered, so latency is 1 clock from iDVAL/iDATA.
  - oDVAL=1 only when state is CAPTURE, iDVAL=1, CROP_X0 <= X < CROP_X0+CROP_W, and ysel <= Y < ysel+CROP_H.
  - Window comparisons use 17-bit sums, so there is no overflow.
  - oDATA is updated with iDATA only when oDVAL is set; otherwise it holds.
- oYSEL follows ysel: it updates at the SEARCH latch and after the CHECK clamp, and holds through IDLE until the next latch.
- oBUSY is registered, derived from the next state. It goes high the clock after iSTART and low in the cycle oDONE or oERR pulses.
- Each capture yields exactly CROP_W*CROP_H oDVAL pulses: 76800 at the defaults.
- Gaps in iDVAL stall the counters only. No pixels are lost or duplicated.

Test Plan:
- Reset, then iSTART mid-frame with iYSTART=100 -> nothing happens until SOF; SEARCH runs for exactly 307200 iDVAL beats; CAPTURE frame gives oDVAL for rows 100..339, cols 160..479, 76800 pulses in total; oDONE pulses once; oYSEL=100.
- iYSTART=300 at end of SEARCH -> oYSEL=240; rows 240..479 captured; 76800 pulses.
- iYSTART=0 -> oERR pulses one cycle after SEARCH EOF; no oDVAL ever; oBUSY falls; oDONE stays 0.
- iDVAL toggled 1/0 at random during CAPTURE with iYSTART=50 -> oDVAL count still 76800; each oDATA equals the iDATA of the previous clock.
- iABORT in the middle of CAPTURE -> oDVAL stops on the next clock; IDLE; no oDONE. A second iSTART during SEARCH is ignored.
- iRST pulsed low in WAIT_CAP -> all outputs 0 immediately; the counters restart from 0 on the next iDVAL.
